// File: rtl/core_pkg.sv
// Shared loader types and constants: FSM state encoding, header size and the
// RV32I NOP returned for out-of-range fetches.
package core_pkg;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_RUN,
        S_ERR
    } loader_state_e;

    localparam int          LDR_HDR_BYTES = 2;
    localparam logic [31:0] RV_NOP        = 32'h00000013;

    function automatic logic is_load_state(input loader_state_e s);
        return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction memory: one synchronous write port and one asynchronous read port
// so the core can fetch in the same cycle it presents an address.
module imem_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // No reset: contents survive both reset and reload.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holds the core in reset until the load completes, and serves core fetches.
//
//   state  | meaning
//   S_LEN0 | waiting for header byte 0 (N[7:0])
//   S_LEN1 | waiting for header byte 1 (N[15:8])
//   S_DATA | assembling and writing data words
//   S_RUN  | load complete, core released
//   S_ERR  | header N exceeded DEPTH, core held until reload
module imem_loader
    import core_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            reload,
    input  logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] imem_data,
    output logic            core_reset,
    output logic            load_err,
    output logic [15:0]     words_loaded
);

    loader_state_e   state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [1:0]      lane_q, lane_d;
    logic [23:0]     bytes_q, bytes_d;
    logic [AW-1:0]   word_idx_q, word_idx_d;
    logic [15:0]     words_q, words_d;
    logic            err_q, err_d;

    logic            xfer;
    logic [15:0]     hdr_len;
    logic            last_word;
    logic            ram_we;
    logic [XLEN-1:0] ram_wdata;
    logic [XLEN-1:0] ram_rdata;

    assign in_ready  = is_load_state(state_q) && !reset && !reload;
    assign xfer      = in_valid && in_ready;
    assign hdr_len   = {in_data, len_q[7:0]};
    assign last_word = (words_q == len_q - 16'd1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        lane_d     = lane_q;
        bytes_d    = bytes_q;
        word_idx_d = word_idx_q;
        words_d    = words_q;
        err_d      = err_q;
        ram_we     = 1'b0;
        // Lane-3 byte goes straight into the word without being registered.
        ram_wdata  = XLEN'({in_data, bytes_q});

        if (reload) begin
            state_d    = S_LEN0;
            len_d      = '0;
            lane_d     = '0;
            word_idx_d = '0;
            words_d    = '0;
            err_d      = 1'b0;
        end else begin
            unique case (state_q)
                S_LEN0: begin
                    if (xfer) begin
                        len_d[7:0] = in_data;
                        state_d    = S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        len_d = hdr_len;
                        if (hdr_len == 16'd0) begin
                            state_d = S_RUN;
                        end else if ({1'b0, hdr_len} > 17'(DEPTH)) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        bytes_d[{lane_q, 3'b000} +: 8] = in_data;
                        lane_d = lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            ram_we     = 1'b1;
                            word_idx_d = word_idx_q + 1'b1;
                            words_d    = words_q + 16'd1;
                            if (last_word) begin
                                state_d = S_RUN;
                            end
                        end
                    end
                end
                S_RUN, S_ERR: begin
                end
                default: begin
                    state_d = S_LEN0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LEN0;
            len_q      <= '0;
            lane_q     <= '0;
            bytes_q    <= '0;
            word_idx_q <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            lane_q     <= lane_d;
            bytes_q    <= bytes_d;
            word_idx_q <= word_idx_d;
            words_q    <= words_d;
            err_q      <= err_d;
        end
    end

    imem_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we && !reset),
        .waddr (word_idx_q),
        .wdata (ram_wdata),
        .raddr (imem_addr[AW+1:2]),
        .rdata (ram_rdata)
    );

    // Byte offset bits are irrelevant for word fetches.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^imem_addr[1:0];

    assign imem_data    = (imem_addr[XLEN-1:AW+2] == '0) ? ram_rdata : XLEN'(RV_NOP);
    assign core_reset   = reset || (state_q != S_RUN);
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a byte-count based reference model.
module tb_imem_loader;
    import core_pkg::*;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 64;
    localparam int AW     = $clog2(DEPTH);
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;

    typedef logic [7:0] byteq_t[$];

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            reload = 1'b0;
    logic [XLEN-1:0] imem_addr = '0;
    logic [XLEN-1:0] imem_data;
    logic            core_reset;
    logic            load_err;
    logic [15:0]     words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .core_reset   (core_reset),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame progress tracked as a count of accepted bytes.
    int          m_mode  = M_LOAD;
    int          m_k     = 0;
    int          m_n     = 0;
    int          m_words = 0;
    bit          m_err   = 0;
    bit          inited  = 0;
    logic [31:0] m_buf   = '0;
    logic [31:0] mref [DEPTH];
    bit          mwr  [DEPTH];

    task automatic model_clear();
        m_mode  = M_LOAD;
        m_k     = 0;
        m_n     = 0;
        m_words = 0;
        m_err   = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit rl, input bit rs, output bit xfer);
        logic [31:0] a;
        int          idx;
        int          lane;
        bit          exp_rdy;
        idx = $urandom_range(DEPTH - 1);
        if ($urandom_range(9) == 0) a = $urandom | 32'h0010_0000;
        else                        a = (idx << 2) | $urandom_range(3);
        in_valid  = v;
        in_data   = d;
        reload    = rl;
        reset     = rs;
        imem_addr = a;
        #1;
        exp_rdy = (m_mode == M_LOAD) && !rs && !rl;
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("core_reset", 32'(core_reset), 32'(rs || (m_mode != M_RUN)));
        if (inited) begin
            check_eq("words_loaded", 32'(words_loaded), 32'(m_words));
            check_eq("load_err", 32'(load_err), 32'(m_err));
        end
        if (a[31:AW+2] != 0)  check_eq("fetch_nop", imem_data, RV_NOP);
        else if (mwr[idx])    check_eq("fetch_mem", imem_data, mref[idx]);
        xfer = v && exp_rdy;
        if (rs) begin
            model_clear();
            inited = 1;
        end else if (rl) begin
            model_clear();
        end else if (xfer) begin
            if (m_k == 0) begin
                m_n = int'(d);
            end else if (m_k == 1) begin
                m_n += int'(d) * 256;
                if (m_n == 0) m_mode = M_RUN;
                else if (m_n > DEPTH) begin
                    m_mode = M_ERR;
                    m_err  = 1;
                end
            end else begin
                lane = (m_k - LDR_HDR_BYTES) % 4;
                m_buf[8*lane +: 8] = d;
                if (lane == 3) begin
                    mref[m_words] = m_buf;
                    mwr[m_words]  = 1;
                    m_words++;
                    if (m_words == m_n) m_mode = M_RUN;
                end
            end
            m_k++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int cnt);
        bit x;
        for (int i = 0; i < cnt; i++) step(0, 8'($urandom), 0, 0, x);
    endtask

    task automatic do_reload();
        bit x;
        step($urandom_range(1), 8'($urandom), 1, 0, x);
    endtask

    task automatic do_reset();
        bit x;
        step($urandom_range(1), 8'($urandom), 0, 1, x);
    endtask

    // toggle=1: in_valid alternates and a 5-cycle gap is inserted mid-word.
    task automatic send_frame(input byteq_t q, input int gap_pct, input bit toggle, input int abort_at);
        int  i = 0;
        int  cyc = 0;
        bit  gapped = 0;
        bit  v;
        bit  x;
        while (i < q.size() && cyc < 4000) begin
            if (i == abort_at) begin
                step(1, q[i], 1, 0, x);
                return;
            end
            if (toggle) begin
                if (i == 5 && !gapped) begin
                    idle(5);
                    gapped = 1;
                end
                v = (cyc % 2) == 0;
            end else begin
                v = $urandom_range(99) >= gap_pct;
            end
            step(v, q[i], 0, 0, x);
            if (x) i++;
            cyc++;
            if (m_mode == M_ERR) begin
                for (int j = 0; j < 3; j++) step(1, 8'($urandom), 0, 0, x);
                return;
            end
        end
        if (cyc >= 4000) check_eq("frame_budget", 32'(i), 32'(q.size()));
    endtask

    task automatic fetch_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        imem_addr = addr;
        #1;
        check_eq(tag, imem_data, exp);
    endtask

    task automatic build_frame(input int n, input int payload_words, output byteq_t q);
        q = {};
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * payload_words; i++) q.push_back(8'($urandom));
    endtask

    initial begin
        byteq_t fa, fz, fe, fb, fp, fr;
        int     n;
        int     r;
        for (int i = 0; i < DEPTH; i++) mwr[i] = 0;
        fa = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        fz = '{8'h00, 8'h00};
        fe = '{8'h41, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        fb = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        fp = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03};

        @(negedge clk);
        do_reset();
        do_reset();
        check_eq("rst_words", 32'(words_loaded), 32'd0);
        check_eq("rst_err", 32'(load_err), 32'd0);

        send_frame(fa, 0, 0, -1);
        idle(2);
        check_eq("a_words", 32'(words_loaded), 32'd2);
        fetch_chk("a_fetch0", 32'h0, 32'h00500513);
        fetch_chk("a_fetch4", 32'h4, 32'h00A00593);

        do_reload();
        send_frame(fa, 0, 1, -1);
        idle(2);
        fetch_chk("gap_fetch0", 32'h0, 32'h00500513);
        fetch_chk("gap_fetch4", 32'h6, 32'h00A00593);

        do_reload();
        send_frame(fz, 0, 0, -1);
        idle(3);
        check_eq("n0_core_reset", 32'(core_reset), 32'd0);

        do_reload();
        send_frame(fe, 0, 0, -1);
        check_eq("err_flag", 32'(load_err), 32'd1);
        do_reload();
        idle(1);

        send_frame(fa, 0, 0, -1);
        idle(1);
        do_reload();
        send_frame(fb, 10, 0, -1);
        idle(2);
        fetch_chk("b_fetch0", 32'h0, 32'hDEADBEEF);
        fetch_chk("b_fetch4", 32'h4, 32'h00A00593);

        do_reload();
        send_frame(fp, 0, 0, -1);
        do_reset();
        check_eq("mid_rst_words", 32'(words_loaded), 32'd0);
        check_eq("mid_rst_core", 32'(core_reset), 32'd1);
        send_frame(fa, 0, 0, -1);
        idle(1);
        fetch_chk("fresh_fetch0", 32'h0, 32'h00500513);
        fetch_chk("oob_fetch", 32'h00001000, 32'h00000013);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(9);
            if (r < 6)       n = $urandom_range(5) + 1;
            else if (r == 6) n = 0;
            else if (r == 7) n = DEPTH;
            else if (r == 8) n = DEPTH + 1 + $urandom_range(300);
            else             n = 65535;
            build_frame(n, (n > DEPTH) ? 1 : n, fr);
            if ($urandom_range(9) == 0) do_reset();
            else if (m_mode != M_LOAD || $urandom_range(4) == 0) do_reload();
            send_frame(fr, $urandom_range(60), 0,
                       ($urandom_range(4) == 0) ? $urandom_range(fr.size() - 1) : -1);
            idle($urandom_range(3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
